// File: rtl/md_pair_scheduler.sv
// Pair sequencer for the MD force datapath: walks home cells, their clipped
// 3x3x3 neighbour windows and all particle pairs, one pair per handshake.
module md_pair_scheduler #(
  parameter int BLOCK_SIDE = 4,
  parameter int DENSITY    = 10,
  parameter int ADDR_W     = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pair_valid,
  input  logic              pair_ready,
  output logic [ADDR_W-1:0] home_addr,
  output logic [ADDR_W-1:0] nbr_addr,
  output logic              pair_self,
  output logic              pair_last,
  output logic              cell_last,
  output logic [31:0]       pair_count
);

  localparam int CW = (BLOCK_SIDE > 1) ? $clog2(BLOCK_SIDE) : 1;
  localparam int PW = (DENSITY > 1) ? $clog2(DENSITY) : 1;
  localparam logic [CW-1:0] CMAX = CW'(BLOCK_SIDE - 1);
  localparam logic [PW-1:0] PMAX = PW'(DENSITY - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic [CW-1:0] bx, by, bz;
    logic [CW-1:0] nx, ny, nz;
    logic [PW-1:0] p, q;
  } idx_t;

  typedef struct packed {
    logic [ADDR_W-1:0] home;
    logic [ADDR_W-1:0] nbr;
    logic              self_m;
    logic              plast;
    logic              clast;
  } fields_t;

  localparam idx_t IDX0 = idx_t'(0);

  function automatic logic [CW-1:0] lo_f(input logic [CW-1:0] b);
    if (b == CW'(0)) lo_f = CW'(0);
    else             lo_f = b - CW'(1);
  endfunction

  function automatic logic [CW-1:0] hi_f(input logic [CW-1:0] b);
    if (b == CMAX) hi_f = CMAX;
    else           hi_f = b + CW'(1);
  endfunction

  function automatic logic [ADDR_W-1:0] cell_f(input logic [CW-1:0] x, input logic [CW-1:0] y,
                                               input logic [CW-1:0] z);
    cell_f = (ADDR_W'(x) * ADDR_W'(BLOCK_SIDE) + ADDR_W'(y)) * ADDR_W'(BLOCK_SIDE) + ADDR_W'(z);
  endfunction

  // Pair fields are derived from loop coordinates, not from the truncated addresses.
  function automatic fields_t fields_f(input idx_t i);
    fields_f.home   = cell_f(i.bx, i.by, i.bz) * ADDR_W'(DENSITY) + ADDR_W'(i.p);
    fields_f.nbr    = cell_f(i.nx, i.ny, i.nz) * ADDR_W'(DENSITY) + ADDR_W'(i.q);
    fields_f.self_m = (i.nx == i.bx) && (i.ny == i.by) && (i.nz == i.bz) && (i.p == i.q);
    fields_f.plast  = (i.q == PMAX);
    fields_f.clast  = (i.nx == hi_f(i.bx)) && (i.ny == hi_f(i.by)) && (i.nz == hi_f(i.bz)) &&
                      (i.p == PMAX) && (i.q == PMAX);
  endfunction

  state_t  state_q;
  idx_t    idx_q, idx_d;
  logic    final_d;
  fields_t out_q, fields_d, first_s;
  logic    busy_q, done_q, valid_q;
  logic [31:0] count_q;

  // Next loop position: q fastest, then p, neighbour window, home cell.
  always_comb begin
    idx_d   = idx_q;
    final_d = 1'b0;
    if (idx_q.q != PMAX) begin
      idx_d.q = idx_q.q + PW'(1);
    end else begin
      idx_d.q = PW'(0);
      if (idx_q.p != PMAX) begin
        idx_d.p = idx_q.p + PW'(1);
      end else begin
        idx_d.p = PW'(0);
        if (idx_q.nz != hi_f(idx_q.bz)) begin
          idx_d.nz = idx_q.nz + CW'(1);
        end else if (idx_q.ny != hi_f(idx_q.by)) begin
          idx_d.nz = lo_f(idx_q.bz);
          idx_d.ny = idx_q.ny + CW'(1);
        end else if (idx_q.nx != hi_f(idx_q.bx)) begin
          idx_d.nz = lo_f(idx_q.bz);
          idx_d.ny = lo_f(idx_q.by);
          idx_d.nx = idx_q.nx + CW'(1);
        end else begin
          if (idx_q.bz != CMAX) begin
            idx_d.bz = idx_q.bz + CW'(1);
          end else if (idx_q.by != CMAX) begin
            idx_d.bz = CW'(0);
            idx_d.by = idx_q.by + CW'(1);
          end else if (idx_q.bx != CMAX) begin
            idx_d.bz = CW'(0);
            idx_d.by = CW'(0);
            idx_d.bx = idx_q.bx + CW'(1);
          end else begin
            idx_d.bz = CW'(0);
            idx_d.by = CW'(0);
            idx_d.bx = CW'(0);
            final_d  = 1'b1;
          end
          // the new home cell opens its own clipped window
          idx_d.nx = lo_f(idx_d.bx);
          idx_d.ny = lo_f(idx_d.by);
          idx_d.nz = lo_f(idx_d.bz);
        end
      end
    end
  end

  // Field values for the upcoming pair and for the first pair of a sweep.
  always_comb begin
    fields_d = fields_f(idx_d);
    first_s  = fields_f(IDX0);
  end

  // Sweep FSM; every output is registered here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= IDX0;
      out_q   <= fields_t'(0);
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      count_q <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= S_ISSUE;
            idx_q   <= IDX0;
            out_q   <= first_s;
            busy_q  <= 1'b1;
            valid_q <= 1'b1;
            count_q <= 32'd0;
          end
        end
        S_ISSUE: begin
          if (valid_q && pair_ready) begin
            if (count_q != 32'hFFFF_FFFF) count_q <= count_q + 32'd1;
            if (final_d) begin
              state_q <= S_DONE;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              idx_q <= idx_d;
              out_q <= fields_d;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign pair_valid = valid_q;
  assign home_addr  = out_q.home;
  assign nbr_addr   = out_q.nbr;
  assign pair_self  = out_q.self_m;
  assign pair_last  = out_q.plast;
  assign cell_last  = out_q.clast;
  assign pair_count = count_q;

endmodule

// File: tb/tb_md_pair_scheduler.sv
// Directed bench for md_pair_scheduler: three instances (2x2 cells/2 particles,
// 3x3 cells/1 particle, defaults) checked against a loop-order model.
module tb_md_pair_scheduler;

  typedef struct {
    logic [31:0] home;
    logic [31:0] nbr;
    logic [31:0] slf;
    logic [31:0] pl;
    logic [31:0] cl;
  } pair_t;

  logic clk = 1'b0;
  logic reset;
  logic start_s, ready_s;
  int   sel;
  int   total, bad;
  pair_t exp_q[$];
  pair_t hist[$];

  logic start_a, start_b, start_c, ready_a, ready_b, ready_c;
  logic busy_a, done_a, valid_a, self_a, plast_a, clast_a;
  logic busy_b, done_b, valid_b, self_b, plast_b, clast_b;
  logic busy_c, done_c, valid_c, self_c, plast_c, clast_c;
  logic [3:0] home_a, nbr_a;
  logic [4:0] home_b, nbr_b;
  logic [9:0] home_c, nbr_c;
  logic [31:0] count_a, count_b, count_c;
  logic [31:0] o_busy, o_done, o_valid, o_home, o_nbr, o_self, o_plast, o_clast, o_count;

  always #5 clk = ~clk;

  assign start_a = start_s && (sel == 0);
  assign start_b = start_s && (sel == 1);
  assign start_c = start_s && (sel == 2);
  assign ready_a = ready_s && (sel == 0);
  assign ready_b = ready_s && (sel == 1);
  assign ready_c = ready_s && (sel == 2);

  md_pair_scheduler #(.BLOCK_SIDE(2), .DENSITY(2), .ADDR_W(4)) u_a (
    .clk(clk), .reset(reset), .start(start_a), .busy(busy_a), .done(done_a),
    .pair_valid(valid_a), .pair_ready(ready_a), .home_addr(home_a), .nbr_addr(nbr_a),
    .pair_self(self_a), .pair_last(plast_a), .cell_last(clast_a), .pair_count(count_a));

  md_pair_scheduler #(.BLOCK_SIDE(3), .DENSITY(1), .ADDR_W(5)) u_b (
    .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b),
    .pair_valid(valid_b), .pair_ready(ready_b), .home_addr(home_b), .nbr_addr(nbr_b),
    .pair_self(self_b), .pair_last(plast_b), .cell_last(clast_b), .pair_count(count_b));

  md_pair_scheduler u_c (
    .clk(clk), .reset(reset), .start(start_c), .busy(busy_c), .done(done_c),
    .pair_valid(valid_c), .pair_ready(ready_c), .home_addr(home_c), .nbr_addr(nbr_c),
    .pair_self(self_c), .pair_last(plast_c), .cell_last(clast_c), .pair_count(count_c));

  always_comb begin
    o_busy = 32'd0; o_done = 32'd0; o_valid = 32'd0; o_home = 32'd0; o_nbr = 32'd0;
    o_self = 32'd0; o_plast = 32'd0; o_clast = 32'd0; o_count = 32'd0;
    case (sel)
      0: begin
        o_busy = 32'(busy_a); o_done = 32'(done_a); o_valid = 32'(valid_a);
        o_home = 32'(home_a); o_nbr = 32'(nbr_a); o_self = 32'(self_a);
        o_plast = 32'(plast_a); o_clast = 32'(clast_a); o_count = count_a;
      end
      1: begin
        o_busy = 32'(busy_b); o_done = 32'(done_b); o_valid = 32'(valid_b);
        o_home = 32'(home_b); o_nbr = 32'(nbr_b); o_self = 32'(self_b);
        o_plast = 32'(plast_b); o_clast = 32'(clast_b); o_count = count_b;
      end
      default: begin
        o_busy = 32'(busy_c); o_done = 32'(done_c); o_valid = 32'(valid_c);
        o_home = 32'(home_c); o_nbr = 32'(nbr_c); o_self = 32'(self_c);
        o_plast = 32'(plast_c); o_clast = 32'(clast_c); o_count = count_c;
      end
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  function automatic int lo(input int b);
    return (b == 0) ? 0 : b - 1;
  endfunction

  function automatic int hi(input int b, input int bs);
    return (b == bs - 1) ? b : b + 1;
  endfunction

  task automatic build_model(input int bs, input int d, input int limit);
    pair_t e;
    exp_q.delete();
    for (int bx = 0; bx < bs; bx++)
      for (int by = 0; by < bs; by++)
        for (int bz = 0; bz < bs; bz++)
          for (int nx = lo(bx); nx <= hi(bx, bs); nx++)
            for (int ny = lo(by); ny <= hi(by, bs); ny++)
              for (int nz = lo(bz); nz <= hi(bz, bs); nz++)
                for (int p = 0; p < d; p++)
                  for (int q = 0; q < d; q++)
                    if (exp_q.size() < limit) begin
                      e.home = 32'(((bx * bs + by) * bs + bz) * d + p);
                      e.nbr  = 32'(((nx * bs + ny) * bs + nz) * d + q);
                      e.slf  = (nx == bx && ny == by && nz == bz && p == q) ? 32'd1 : 32'd0;
                      e.pl   = (q == d - 1) ? 32'd1 : 32'd0;
                      e.cl   = (nx == hi(bx, bs) && ny == hi(by, bs) && nz == hi(bz, bs) &&
                                p == d - 1 && q == d - 1) ? 32'd1 : 32'd0;
                      exp_q.push_back(e);
                    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, o_valid, 32'd0);
    chk({tag, "_busy"},  o_busy,  32'd0);
    chk({tag, "_done"},  o_done,  32'd0);
    chk({tag, "_home"},  o_home,  32'd0);
    chk({tag, "_nbr"},   o_nbr,   32'd0);
    chk({tag, "_self"},  o_self,  32'd0);
    chk({tag, "_plast"}, o_plast, 32'd0);
    chk({tag, "_clast"}, o_clast, 32'd0);
    chk({tag, "_count"}, o_count, 32'd0);
  endtask

  task automatic run_sweep(input int n_exp, input bit full, input bit rnd, input bit hold);
    int idx, cyc;
    bit stalled;
    pair_t prev;
    idx = 0; cyc = 0; stalled = 1'b0;
    hist.delete();
    @(negedge clk);
    start_s = 1'b1;
    ready_s = 1'b0;
    @(negedge clk);
    chk("first_valid", o_valid, 32'd1);
    if (!hold) start_s = 1'b0;
    while (idx < n_exp && cyc < 4 * n_exp + 20 && bad < 20) begin
      chk("valid", o_valid, 32'd1);
      chk("busy", o_busy, 32'd1);
      chk("no_done", o_done, 32'd0);
      if (stalled) begin
        chk("stall_home", o_home, prev.home);
        chk("stall_nbr", o_nbr, prev.nbr);
        chk("stall_clast", o_clast, prev.cl);
      end
      chk("home", o_home, exp_q[idx].home);
      chk("nbr", o_nbr, exp_q[idx].nbr);
      chk("self", o_self, exp_q[idx].slf);
      chk("pair_last", o_plast, exp_q[idx].pl);
      chk("cell_last", o_clast, exp_q[idx].cl);
      chk("count", o_count, 32'(idx));
      prev.home = o_home; prev.nbr = o_nbr; prev.slf = o_self;
      prev.pl = o_plast; prev.cl = o_clast;
      ready_s = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (ready_s) hist.push_back(prev);
      @(negedge clk);
      cyc++;
      if (ready_s) begin
        idx++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
      end
    end
    ready_s = 1'b0;
    chk("handshakes", 32'(idx), 32'(n_exp));
    if (full) begin
      chk("done_pulse", o_done, 32'd1);
      chk("busy_fall", o_busy, 32'd0);
      chk("valid_off", o_valid, 32'd0);
      chk("final_count", o_count, 32'(n_exp));
      @(negedge clk);
      chk("done_once", o_done, 32'd0);
      chk("idle_valid", o_valid, 32'd0);
      chk("idle_count", o_count, 32'(n_exp));
    end
  endtask

  initial begin
    int first_i, n0, n13, ncl, nself;
    total = 0; bad = 0; sel = 0;
    start_s = 1'b0; ready_s = 1'b0; reset = 1'b0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk_zero("reset");
    end
    sel = 0;
    @(negedge clk);
    reset = 1'b1;

    // 2x2x2 grid, 2 particles: 4^3*4 = 256 pairs, ready always high
    build_model(2, 2, 256);
    run_sweep(256, 1'b1, 1'b0, 1'b0);
    chk("a0_home", hist[0].home, 32'd0); chk("a0_nbr", hist[0].nbr, 32'd0);
    chk("a0_self", hist[0].slf, 32'd1);  chk("a0_last", hist[0].pl, 32'd0);
    chk("a1_nbr", hist[1].nbr, 32'd1);   chk("a1_last", hist[1].pl, 32'd1);
    chk("a1_self", hist[1].slf, 32'd0);
    chk("a2_home", hist[2].home, 32'd1); chk("a2_nbr", hist[2].nbr, 32'd0);
    chk("a3_self", hist[3].slf, 32'd1);  chk("a3_last", hist[3].pl, 32'd1);
    chk("a4_home", hist[4].home, 32'd0); chk("a4_nbr", hist[4].nbr, 32'd2);
    first_i = -1; ncl = 0;
    foreach (hist[i]) begin
      if (hist[i].cl != 32'd0) begin
        ncl++;
        if (first_i < 0) first_i = i;
      end
    end
    chk("a_first_cell_last", 32'(first_i), 32'd31);
    chk("a_cl_home", hist[31].home, 32'd1);
    chk("a_cl_nbr", hist[31].nbr, 32'd15);
    chk("a_cell_last_count", 32'(ncl), 32'd8);

    // start held high: no restart mid-sweep, re-accepted right after done
    run_sweep(256, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    start_s = 1'b0;
    chk("restart_valid", o_valid, 32'd1);
    chk("restart_busy", o_busy, 32'd1);
    chk("restart_home", o_home, 32'd0);
    chk("restart_nbr", o_nbr, 32'd0);
    chk("restart_count", o_count, 32'd0);

    // abandon mid-sweep with pair_valid high
    ready_s = 1'b1;
    repeat (10) @(negedge clk);
    ready_s = 1'b0;
    @(negedge clk);
    chk("pre_reset_valid", o_valid, 32'd1);
    chk("pre_reset_count", o_count, 32'd10);
    #2 reset = 1'b0;
    #1 chk_zero("async_reset");
    @(negedge clk);
    chk("reset_no_done", o_done, 32'd0);
    reset = 1'b1;
    build_model(2, 2, 256);
    run_sweep(256, 1'b1, 1'b1, 1'b0);

    // 3x3x3 grid, 1 particle: 7^3 = 343 pairs; interior and corner windows
    sel = 1;
    build_model(3, 1, 343);
    run_sweep(343, 1'b1, 1'b0, 1'b0);
    n0 = 0; n13 = 0; ncl = 0; nself = 0;
    foreach (hist[i]) begin
      if (hist[i].home == 32'd0) n0++;
      if (hist[i].home == 32'd13) n13++;
      if (hist[i].cl != 32'd0) ncl++;
      if (hist[i].slf != 32'd0) nself++;
    end
    chk("b_corner_window", 32'(n0), 32'd8);
    chk("b_interior_window", 32'(n13), 32'd27);
    chk("b_cell_last_count", 32'(ncl), 32'd27);
    chk("b_self_count", 32'(nself), 32'd27);

    // defaults, random backpressure, first 900 pairs (home cell 0 and into cell 1)
    sel = 2;
    build_model(4, 10, 900);
    run_sweep(900, 1'b0, 1'b1, 1'b0);
    first_i = -1; n0 = 0;
    foreach (hist[i]) begin
      if (hist[i].nbr >= 32'd10 && first_i < 0) first_i = i;
      if (hist[i].home < 32'd10) n0++;
    end
    chk("c_first_nbr_change", 32'(first_i), 32'd100);
    chk("c_nbr_at_100", hist[100].nbr, 32'd10);
    chk("c_nbr_at_99", hist[99].nbr, 32'd9);
    chk("c_home0_pairs", 32'(n0), 32'd800);
    chk("c_cell_last_799", hist[799].cl, 32'd1);
    chk("c_nbr_at_799", hist[799].nbr, 32'd219);
    chk("c_home_at_800", hist[800].home, 32'd10);
    chk("c_nbr_at_800", hist[800].nbr, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
